rgb_to_grayscale: RTL
=====================

# rgb_to_grayscale

Streaming colour-to-luma converter that sits directly upstream of `sobel_kernel`. It takes one 24-bit RGB pixel per valid cycle and emits one 8-bit grayscale pixel per cycle, using the same `grayscale`/`done` strobe convention that `sobel_kernel` consumes on `grayscale_i`/`done_i`. It also tracks the raster position of each output pixel and flags the last pixel of every frame.

## Interface
- `IMG_WIDTH`, default 640: pixels per line; must be ≥ 2.
- `IMG_HEIGHT`, default 480: lines per frame; must be ≥ 2.
- `clk`, input, 1: the single clock; all logic is rising-edge.
- `rst`, input, 1: synchronous, active-high reset.
- `rgb_i`, input, 24: pixel; [23:16] = R, [15:8] = G, [7:0] = B; sampled only when `valid_i` = 1.
- `valid_i`, input, 1: `rgb_i` holds a pixel this cycle; may drop at any cycle (bubbles allowed).
- `grayscale_o`, output, 8: luma result; meaningful only while `done_o` = 1.
- `done_o`, output, 1: one-cycle strobe per output pixel; connects to `sobel_kernel.done_i`.
- `x_o`, output, $clog2(IMG_WIDTH): column of the pixel currently on `grayscale_o`.
- `y_o`, output, $clog2(IMG_HEIGHT): row of the pixel currently on `grayscale_o`.
- `frame_done_o`, output, 1: asserted with `done_o` on pixel (IMG_WIDTH-1, IMG_HEIGHT-1).

## Operation
- **Luma formula:** Y = (77·R + 150·G + 29·B + 128) >> 8, computed in unsigned 16-bit arithmetic.
  - Coefficients sum to 256, so the maximum is 65408 >> 8 = 255. No saturation logic is needed.
  - Bits [15:8] of the rounded sum form `grayscale_o`.
- **Pipeline:** three register stages, each carrying its own valid bit. There is no backpressure; the block accepts one pixel per cycle at all times.
  - S1: register the three products (each 16 bits wide).
  - S2: register the sum of the three products plus 128.
  - S3: register bits [15:8] onto `grayscale_o`; the S3 valid bit drives `done_o`.
- **Position counters** (`x_o`, `y_o`) advance on output pixels, not input pixels. On each cycle where S3 valid is 1:
  - if `x_o` = IMG_WIDTH-1, `x_o` goes to 0 and `y_o` increments;
  - if `y_o` = IMG_HEIGHT-1 as well, `y_o` wraps to 0 (start of next frame);
  - otherwise `x_o` increments.
- **Output alignment:** `x_o`/`y_o` are registered together with `grayscale_o`, so the values presented alongside `done_o` = 1 are the position of that pixel. Equivalently, the counters hold the position of the next pixel to be emitted, and their outputs are aligned to S3.
- **End of frame:** `frame_done_o` = `done_o` AND (`x_o` = IMG_WIDTH-1) AND (`y_o` = IMG_HEIGHT-1), registered in S3. It therefore pulses exactly once per frame, coincident with the final `done_o`.
- **Bubbles:** when `valid_i` = 0, a bubble propagates down the pipeline. `done_o` = 0 for that cycle and the counters hold. `grayscale_o` also holds its last value, because the data registers load only when their stage valid is 1.
- **Frame boundary:** there is no frame-start input. The frame boundary is defined purely by counting IMG_WIDTH·IMG_HEIGHT output pixels.

## Timing
- **Reset values:** `grayscale_o` = 0, `done_o` = 0, `x_o` = 0, `y_o` = 0, `frame_done_o` = 0. All stage valid bits and the internal position counter are cleared.
- **Latency:** a pixel sampled at rising edge N (`valid_i` = 1) appears with `done_o` = 1 in the cycle after edge N+2, i.e. 3 cycles of latency. Throughput is 1 pixel per clock.
- **Reset mid-operation:**
  - Pixels in flight are discarded; `done_o` is 0 for the 3 cycles after reset deasserts unless new valid input arrives.
  - Position restarts at (0,0).
  - Input presented in the same cycle as `rst` = 1 is ignored.
- **Back-to-back frames:** the pixel after the `frame_done_o` pixel is (0,0) of the next frame, with no dead cycle.
- **Continuous input:** with `valid_i` held at 1, `done_o` stays at 1 continuously from cycle 3 onward.

## Test plan
- **Colour corners:** RGB = FFFFFF → 255; FF0000 → 77; 00FF00 → 149; 0000FF → 29; 000000 → 0; (100,150,200) → 141. Each appears exactly 3 cycles after its input.
- **Gapped stream:** apply `valid_i` pattern 1,0,1,1,0,0,1. `done_o` must reproduce the same pattern delayed by 3 cycles, with `x_o` = 0,1,2,3 on the four output strobes.
- **Full frame** (IMG_WIDTH = 4, IMG_HEIGHT = 3) with continuous valid:
  - 12 `done_o` strobes in total;
  - `x_o` wraps 3 → 0 while `y_o` increments;
  - `frame_done_o` is high only on (3,2);
  - the next pixel is reported at (0,0).
- **Reset mid-frame:** assert `rst` for 1 cycle after 5 pixels, with 2 still in flight.
  - No `done_o` appears for the in-flight pixels.
  - The next accepted pixel is reported at (0,0).
  - All outputs read 0 in the cycle after reset.
- **Random regression:** 10k random pixels with random `valid_i` at 70% density, compared against a reference model of the luma formula, position counters and `frame_done_o` count.

Source files
------------

// File: rtl/rgb_to_grayscale_if.sv
// Pixel stream bundle between an RGB source and the luma converter.
// slave: rgb_i/valid_i in; grayscale_o/done_o/x_o/y_o/frame_done_o out.
interface rgb_to_grayscale_if #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
);
   localparam int XW = $clog2(IMG_WIDTH);
   localparam int YW = $clog2(IMG_HEIGHT);

   logic [23:0]   rgb_i;
   logic          valid_i;
   logic [7:0]    grayscale_o;
   logic          done_o;
   logic [XW-1:0] x_o;
   logic [YW-1:0] y_o;
   logic          frame_done_o;

   modport slave (
      input  rgb_i,
      input  valid_i,
      output grayscale_o,
      output done_o,
      output x_o,
      output y_o,
      output frame_done_o
   );

   modport master (
      output rgb_i,
      output valid_i,
      input  grayscale_o,
      input  done_o,
      input  x_o,
      input  y_o,
      input  frame_done_o
   );
endinterface

// File: rtl/rgb_to_grayscale.sv
// Three-stage RGB to 8-bit luma converter with raster position tracking.
// Ports: clk, rst (sync, active-high), px (slave modport of the stream bundle).
module rgb_to_grayscale #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input logic               clk,
   input logic               rst,
   rgb_to_grayscale_if.slave px
);
   localparam int XW = $clog2(IMG_WIDTH);
   localparam int YW = $clog2(IMG_HEIGHT);
   localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

   logic          v1_q, v1_d;
   logic [15:0]   pr_q, pr_d;
   logic [15:0]   pg_q, pg_d;
   logic [15:0]   pb_q, pb_d;
   logic          v2_q, v2_d;
   logic [15:0]   sum_q, sum_d;
   logic          done_q, done_d;
   logic [7:0]    gray_q, gray_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic          fd_q, fd_d;
   // position of the next pixel to leave S3
   logic [XW-1:0] cx_q, cx_d;
   logic [YW-1:0] cy_q, cy_d;

   always_comb begin
      v1_d = px.valid_i;
      pr_d = pr_q;
      pg_d = pg_q;
      pb_d = pb_q;
      if (px.valid_i) begin
         pr_d = {8'd0, px.rgb_i[23:16]} * 16'd77;
         pg_d = {8'd0, px.rgb_i[15:8]}  * 16'd150;
         pb_d = {8'd0, px.rgb_i[7:0]}   * 16'd29;
      end

      v2_d  = v1_q;
      sum_d = sum_q;
      // coefficients sum to 256, so the rounded sum never exceeds 16 bits
      if (v1_q)
         sum_d = pr_q + pg_q + pb_q + 16'd128;

      done_d = v2_q;
      gray_d = gray_q;
      x_d    = x_q;
      y_d    = y_q;
      cx_d   = cx_q;
      cy_d   = cy_q;
      fd_d   = 1'b0;
      if (v2_q) begin
         gray_d = sum_q[15:8];
         x_d    = cx_q;
         y_d    = cy_q;
         fd_d   = (cx_q == X_LAST) && (cy_q == Y_LAST);
         if (cx_q == X_LAST) begin
            cx_d = '0;
            cy_d = (cy_q == Y_LAST) ? '0 : cy_q + YW'(1);
         end else begin
            cx_d = cx_q + XW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q   <= 1'b0;
         pr_q   <= '0;
         pg_q   <= '0;
         pb_q   <= '0;
         v2_q   <= 1'b0;
         sum_q  <= '0;
         done_q <= 1'b0;
         gray_q <= '0;
         x_q    <= '0;
         y_q    <= '0;
         fd_q   <= 1'b0;
         cx_q   <= '0;
         cy_q   <= '0;
      end else begin
         v1_q   <= v1_d;
         pr_q   <= pr_d;
         pg_q   <= pg_d;
         pb_q   <= pb_d;
         v2_q   <= v2_d;
         sum_q  <= sum_d;
         done_q <= done_d;
         gray_q <= gray_d;
         x_q    <= x_d;
         y_q    <= y_d;
         fd_q   <= fd_d;
         cx_q   <= cx_d;
         cy_q   <= cy_d;
      end
   end

   assign px.grayscale_o  = gray_q;
   assign px.done_o       = done_q;
   assign px.x_o          = x_q;
   assign px.y_o          = y_q;
   assign px.frame_done_o = fd_q;
endmodule
